// File: rtl/flgmatch_pkg.sv
// Shared types and width helpers for the sparse-flag match scanner.
package flgmatch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int DEF_FLAG_WIDTH = 32;
  localparam int OFS_WIDTH = $clog2(DEF_FLAG_WIDTH);
  localparam int NUM_WIDTH = OFS_WIDTH + 1;

  // Offsets index below a position, so they never exceed FLAG_WIDTH-1.
  function automatic int ofsWidth(input int flagWidth);
    return $clog2(flagWidth);
  endfunction

endpackage

// File: rtl/flg_match_scan_popcnt.sv
// Combinational population count of a WIDTH-bit word.
module flg_popcnt #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic [WIDTH-1:0]     data,
  output logic [CNT_WIDTH-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_WIDTH'(data[i]);
    end
  end

endmodule

// File: rtl/flg_match_scan.sv
// Streams (act, weight) compressed addresses for every position where both flags are set.
// Optional FLGMATCH_CNT_EN adds the MatchNum output.
module flg_match_scan
  import flgmatch_pkg::*;
#(
  parameter int FLAG_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        FlgVld,
  output logic                        FlgRdy,
  input  logic [FLAG_WIDTH-1:0]       Act,
  input  logic [FLAG_WIDTH-1:0]       Wei,
  input  logic [ADDR_WIDTH-1:0]       ActBase,
  input  logic [ADDR_WIDTH-1:0]       WeiBase,
  output logic                        OutVld,
  input  logic                        OutRdy,
  output logic [ADDR_WIDTH-1:0]       ActAddr,
  output logic [ADDR_WIDTH-1:0]       WeiAddr,
  output logic                        OutLast,
  output logic                        WordDone,
  output logic [$clog2(FLAG_WIDTH):0] ActNum,
`ifdef FLGMATCH_CNT_EN
  output logic [$clog2(FLAG_WIDTH):0] MatchNum,
`endif
  output logic [$clog2(FLAG_WIDTH):0] WeiNum
);

  localparam int OFS_W = ofsWidth(FLAG_WIDTH);
  localparam int NUM_W = OFS_W + 1;
  localparam logic [FLAG_WIDTH-1:0] FLAG_ONE = FLAG_WIDTH'(1);

  state_t                  state;
  logic [FLAG_WIDTH-1:0]   actR;
  logic [FLAG_WIDTH-1:0]   weiR;
  logic [FLAG_WIDTH-1:0]   rem;
  logic [ADDR_WIDTH-1:0]   actBaseR;
  logic [ADDR_WIDTH-1:0]   weiBaseR;

  logic                    loadNow;
  logic                    popNow;
  logic [FLAG_WIDTH-1:0]   matchIn;
  logic [FLAG_WIDTH-1:0]   remNext;
  logic [FLAG_WIDTH-1:0]   actNext;
  logic [FLAG_WIDTH-1:0]   weiNext;
  logic [ADDR_WIDTH-1:0]   actBaseNext;
  logic [ADDR_WIDTH-1:0]   weiBaseNext;
  logic [FLAG_WIDTH-1:0]   lsbNext;
  logic [FLAG_WIDTH-1:0]   belowNext;
  logic [OFS_W-1:0]        actBelow;
  logic [OFS_W-1:0]        weiBelow;

  // Addresses are registered, so they are derived from next-cycle flag state.
  always_comb begin
    loadNow     = (state == IDLE) && FlgVld;
    popNow      = (state == SCAN) && OutRdy;
    matchIn     = Act & Wei;
    remNext     = rem;
    actNext     = actR;
    weiNext     = weiR;
    actBaseNext = actBaseR;
    weiBaseNext = weiBaseR;
    if (loadNow) begin
      remNext     = matchIn;
      actNext     = Act;
      weiNext     = Wei;
      actBaseNext = ActBase;
      weiBaseNext = WeiBase;
    end else if (popNow) begin
      remNext = rem & ~(rem & (-rem));
    end
    lsbNext   = remNext & (-remNext);
    belowNext = lsbNext - FLAG_ONE;
  end

  flg_popcnt #(.WIDTH(FLAG_WIDTH), .CNT_WIDTH(OFS_W)) actBelowCnt (
    .data  (actNext & belowNext),
    .count (actBelow)
  );

  flg_popcnt #(.WIDTH(FLAG_WIDTH), .CNT_WIDTH(OFS_W)) weiBelowCnt (
    .data  (weiNext & belowNext),
    .count (weiBelow)
  );

  flg_popcnt #(.WIDTH(FLAG_WIDTH), .CNT_WIDTH(NUM_W)) actNumCnt (
    .data  (actR),
    .count (ActNum)
  );

  flg_popcnt #(.WIDTH(FLAG_WIDTH), .CNT_WIDTH(NUM_W)) weiNumCnt (
    .data  (weiR),
    .count (WeiNum)
  );

`ifdef FLGMATCH_CNT_EN
  flg_popcnt #(.WIDTH(FLAG_WIDTH), .CNT_WIDTH(NUM_W)) matchNumCnt (
    .data  (actR & weiR),
    .count (MatchNum)
  );
`endif

  // SCAN is simply "matches remain"; the last handshake or an empty load returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      actR     <= '0;
      weiR     <= '0;
      rem      <= '0;
      actBaseR <= '0;
      weiBaseR <= '0;
      FlgRdy   <= 1'b1;
      OutVld   <= 1'b0;
      OutLast  <= 1'b0;
      WordDone <= 1'b0;
      ActAddr  <= '0;
      WeiAddr  <= '0;
    end else begin
      state    <= (remNext != '0) ? SCAN : IDLE;
      actR     <= actNext;
      weiR     <= weiNext;
      rem      <= remNext;
      actBaseR <= actBaseNext;
      weiBaseR <= weiBaseNext;
      FlgRdy   <= (remNext == '0);
      OutVld   <= (remNext != '0);
      OutLast  <= (remNext != '0) && ((remNext & (remNext - FLAG_ONE)) == '0);
      WordDone <= (loadNow && (matchIn == '0)) || (popNow && OutLast);
      ActAddr  <= actBaseNext + ADDR_WIDTH'(actBelow);
      WeiAddr  <= weiBaseNext + ADDR_WIDTH'(weiBelow);
    end
  end

endmodule
